p2s_serializer: RTL
===================

P2S_SERIALIZER -- requirements
Module: p2s_serializer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK and RST.
REQ-002 Parameter WIDTH, default 8, SHALL set the parallel word width in bits; legal range 2..64.
REQ-003 Parameter MSB_FIRST, default 1, SHALL select the serial bit order: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-004 CLK  input  1  rising-edge clock for all state.
REQ-005 RST  input  1  synchronous active-high reset.
REQ-006 ENB  input  1  global enable; low freezes all state.
REQ-007 data_in  input  WIDTH  parallel word.
REQ-008 valid_in  input  1  data_in holds a word to transfer.
REQ-009 ready_out  output  1  the block can accept a word this cycle.
REQ-010 Q  output  1  serial data bit.
REQ-011 valid_out  output  1  Q carries a valid bit.
REQ-012 last_out  output  1  Q is the final bit of its word.

Function
REQ-013 A word SHALL be accepted on a rising CLK edge where valid_in, ready_out and ENB are all high, and on no other edge.
REQ-014 ready_out SHALL be ENB AND (hold buffer empty), decoded from registered state only.
REQ-015 Datapath: a WIDTH-bit shift register, a bit counter of clog2(WIDTH) bits, an active flag, and a one-word hold buffer with a full flag.
REQ-016 When the shifter is idle, or is on its last bit with the hold buffer empty, an accepted word SHALL load directly into the shifter (bypass).
REQ-017 Otherwise an accepted word SHALL go to the hold buffer.
REQ-018 Latency: for a word accepted at edge N into an idle shifter, bit k SHALL appear on Q in the cycle after edge N+k, for k = 0..WIDTH-1.
REQ-019 Each word SHALL occupy exactly WIDTH consecutive enabled cycles with valid_out high.
REQ-020 On the edge that retires the last bit, a full hold buffer SHALL transfer into the shifter and empty, so consecutive words stream with no idle cycle.
REQ-021 last_out SHALL be high only when valid_out is high and the counter equals WIDTH-1.
REQ-022 While ENB is low:
  - shifter, counter, active flag and hold buffer SHALL keep their values;
  - Q, valid_out, last_out and ready_out SHALL be 0.
REQ-023 When ENB returns high, serialization SHALL resume at the frozen bit with no bit lost or repeated.
REQ-024 When valid_out is 0, Q SHALL be 0; the output is never high-impedance.
REQ-025 data_in SHALL be ignored on edges where no word is accepted.
REQ-026 After the last bit, with the hold buffer empty and no bypass accept, the active flag SHALL clear and valid_out SHALL fall the next cycle.

Reset
REQ-027 RST high on an edge SHALL clear the shifter, counter, active flag, hold buffer and hold full flag, regardless of ENB and valid_in.
REQ-028 Output values after reset SHALL be: Q=0, valid_out=0, last_out=0, ready_out=ENB.
REQ-029 RST during a word SHALL discard both the in-flight word and the held word; no partial bits SHALL be emitted afterwards.

Structure
REQ-030 A shared package/include p2s_defs SHALL hold the clog2 counter-width function and the MSB_FIRST encoding constants.
REQ-031 The hold buffer plus its full flag SHALL be one sub-module, p2s_hold_buf, with load, unload and clear ports.
REQ-032 The shifter, counter and output decode SHALL reside in p2s_serializer.

Verification
REQ-033 Reset: RST high 2 cycles with ENB=1 -> Q=0, valid_out=0, last_out=0, ready_out=1.
REQ-034 Single word, WIDTH=8, MSB_FIRST=1, 8'hA5 accepted at edge 0 -> cycles 1..8 Q=1,0,1,0,0,1,0,1 with valid_out=1; last_out=1 in cycle 8 only; valid_out=0 in cycle 9.
REQ-035 Back-to-back 8'hA5 then 8'h3C, valid_in held high -> 16 contiguous valid bits A5 then 3C; ready_out=0 from acceptance of 8'h3C into hold until the edge retiring A5's last bit.
REQ-036 Stall: ENB low for 3 cycles after the 4th bit of 8'hA5 -> Q=0 and valid_out=0 for 3 cycles; bits 5..8 (0,1,0,1) then follow with no loss.
REQ-037 Order: MSB_FIRST=0, word 8'h01 -> Q=1 then seven 0s; last_out on the 8th bit.
REQ-038 Mid-word reset: RST after 5 bits of 8'hA5 with 8'h3C held -> next cycle valid_out=0 and ready_out=1; no further bits from either word.

Source files
------------

// File: rtl/p2s_serializer_pkg.sv
// Shared definitions for the parallel-to-serial block: bit-order encodings
// and the counter-width helper.
package p2s_defs;

    localparam bit ORDER_LSB_FIRST = 1'b0;
    localparam bit ORDER_MSB_FIRST = 1'b1;

    // Always at least one bit, so WIDTH=2 still gets a usable counter.
    function automatic int clog2(input int value);
        for (int w = 1; w < 32; w++) begin
            if ((1 << w) >= value) begin
                return w;
            end
        end
        return 32;
    endfunction

endpackage

// File: rtl/p2s_serializer_if.sv
// Word-in / bit-out handshake bundle between a producer and the serializer.
interface p2s_serializer_if #(
    parameter int WIDTH = 8
);
    logic [WIDTH-1:0] data_in;
    logic             valid_in;
    logic             ready_out;
    logic             Q;
    logic             valid_out;
    logic             last_out;

    modport master (
        output data_in,
        output valid_in,
        input  ready_out,
        input  Q,
        input  valid_out,
        input  last_out
    );

    modport slave (
        input  data_in,
        input  valid_in,
        output ready_out,
        output Q,
        output valid_out,
        output last_out
    );
endinterface

// File: rtl/p2s_hold_buf.sv
// One-word skid buffer that lets the next word wait while the shifter is busy.
module p2s_hold_buf #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             clear_i,
    input  logic             load_i,
    input  logic             unload_i,
    input  logic [WIDTH-1:0] data_i,
    output logic [WIDTH-1:0] data_o,
    output logic             full_o
);

    logic [WIDTH-1:0] data_q, data_d;
    logic             full_q, full_d;

    always_comb begin
        data_d = data_q;
        full_d = full_q;
        if (load_i) begin
            data_d = data_i;
            full_d = 1'b1;
        end else if (unload_i) begin
            full_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (clear_i) begin
            data_q <= '0;
            full_q <= 1'b0;
        end else begin
            data_q <= data_d;
            full_q <= full_d;
        end
    end

    assign data_o = data_q;
    assign full_o = full_q;

endmodule

// File: rtl/p2s_serializer.sv
// Parallel-to-serial converter: shifter, bit counter and output decode, with
// a hold buffer so back-to-back words stream without a gap.
module p2s_serializer
    import p2s_defs::*;
#(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = ORDER_MSB_FIRST
) (
    input logic              CLK,
    input logic              RST,
    input logic              ENB,
    p2s_serializer_if.slave  bus
);

    localparam int            CW       = clog2(WIDTH);
    localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

    logic [WIDTH-1:0] shifter_q, shifter_d;
    logic [CW-1:0]    count_q, count_d;
    logic             active_q, active_d;

    logic [WIDTH-1:0] holdData;
    logic             holdFull;
    logic             holdLoad;
    logic             holdUnload;
    logic             ready;
    logic             accept;
    logic             onLastBit;
    logic             serialBit;
    logic             validOut;

    assign ready     = ENB & ~holdFull;
    assign accept    = bus.valid_in & ready;
    assign onLastBit = active_q & (count_q == LAST_IDX);

    // A retiring word hands over to the held word first; only with the hold
    // empty may a fresh word bypass straight into the shifter.
    always_comb begin
        shifter_d  = shifter_q;
        count_d    = count_q;
        active_d   = active_q;
        holdLoad   = 1'b0;
        holdUnload = 1'b0;
        if (ENB) begin
            if (!active_q) begin
                if (accept) begin
                    shifter_d = bus.data_in;
                    count_d   = '0;
                    active_d  = 1'b1;
                end
            end else if (onLastBit) begin
                if (holdFull) begin
                    shifter_d  = holdData;
                    count_d    = '0;
                    holdUnload = 1'b1;
                end else if (accept) begin
                    shifter_d = bus.data_in;
                    count_d   = '0;
                end else begin
                    active_d = 1'b0;
                end
            end else begin
                if (MSB_FIRST == ORDER_MSB_FIRST) begin
                    shifter_d = {shifter_q[WIDTH-2:0], 1'b0};
                end else begin
                    shifter_d = {1'b0, shifter_q[WIDTH-1:1]};
                end
                count_d  = count_q + CW'(1);
                holdLoad = accept;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            shifter_q <= '0;
            count_q   <= '0;
            active_q  <= 1'b0;
        end else begin
            shifter_q <= shifter_d;
            count_q   <= count_d;
            active_q  <= active_d;
        end
    end

    p2s_hold_buf #(
        .WIDTH (WIDTH)
    ) u_hold (
        .clk_i    (CLK),
        .clear_i  (RST),
        .load_i   (holdLoad),
        .unload_i (holdUnload),
        .data_i   (bus.data_in),
        .data_o   (holdData),
        .full_o   (holdFull)
    );

    assign serialBit     = (MSB_FIRST == ORDER_MSB_FIRST) ? shifter_q[WIDTH-1] : shifter_q[0];
    assign validOut      = ENB & active_q;
    assign bus.ready_out = ready;
    assign bus.valid_out = validOut;
    assign bus.Q         = validOut & serialBit;
    assign bus.last_out  = validOut & (count_q == LAST_IDX);

endmodule
